// File: rtl/mem_arb_pkg.sv
// Shared types for the data_memory port arbiter: FSM states, access sizes,
// requester select and the DM alignment rule.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_DONE = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  typedef enum logic {
    SEL_IF = 1'b0,
    SEL_DM = 1'b1
  } req_sel_t;

  // Halfwords need an even address, words a 4-byte aligned one; bytes never fault.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_arb_lat_timer.sv
// Loadable down-counter that flags the edge on which a read issued
// MEM_LAT edges earlier returns its data.
module mem_arb_lat_timer #(
  parameter int MEM_LAT = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic enable,
  output logic done
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] lat_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lat_cnt <= '0;
    end else if (load) begin
      lat_cnt <= LOAD_VAL;
    end else if (enable && (lat_cnt != '0)) begin
      lat_cnt <= lat_cnt - CNT_W'(1);
    end
  end

  assign done = enable && (lat_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single data_memory port between instruction fetch and the
// load/store stage. Optional DM alignment check: MEM_ARB_ALIGN_CHECK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_ready_out,
  output logic [DATA_W-1:0] if_data_out,
  input  logic              dm_req_in,
  input  logic              dm_we_in,
  input  logic [1:0]        dm_size_in,
  input  logic [ADDR_W-1:0] dm_addr_in,
  input  logic [DATA_W-1:0] dm_wdata_in,
  output logic              dm_ready_out,
  output logic [DATA_W-1:0] dm_rdata_out,
  output logic              dm_err_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_wdata_out,
  output logic              mem_re_out,
  output logic              mem_we_out,
  output logic [1:0]        mem_size_out,
  input  logic [DATA_W-1:0] mem_rdata_in,
  output logic              stall_out
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  state_t          state, state_nxt;
  req_sel_t        sel;
  logic [SC_W-1:0] starve_cnt;
  logic            grant_if, grant_dm, dm_misaligned, lat_done;
  logic            issue_rd, issue_wr, cap_if, cap_dm, wr_ack, timer_load;

  // DM has priority until it has starved a waiting fetch STARVE_MAX times.
  assign grant_dm = (state == IDLE) && dm_req_in && !(if_req_in && (starve_cnt == STARVE_LIM));
  assign grant_if = (state == IDLE) && if_req_in && !grant_dm;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic err_pend;

  assign dm_misaligned = is_misaligned(dm_size_in, dm_addr_in[1:0]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_pend   <= 1'b0;
      dm_err_out <= 1'b0;
    end else begin
      if (grant_dm) begin
        err_pend <= dm_misaligned;
      end
      dm_err_out <= wr_ack && err_pend;
    end
  end
`else
  assign dm_misaligned = 1'b0;
  assign dm_err_out    = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A rejected misaligned access reuses the store completion path.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_if) begin
          state_nxt = RD_WAIT;
        end else if (grant_dm) begin
          state_nxt = (dm_we_in || dm_misaligned) ? WR_DONE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_done) begin
          state_nxt = IDLE;
        end
      end
      WR_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_rd   = grant_if || (grant_dm && !dm_we_in && !dm_misaligned);
    issue_wr   = grant_dm && dm_we_in && !dm_misaligned;
    cap_if     = lat_done && (sel == SEL_IF);
    cap_dm     = lat_done && (sel == SEL_DM);
    wr_ack     = (state == WR_DONE);
    timer_load = issue_rd;
  end

  mem_arb_lat_timer #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_timer (
    .clock  (clock),
    .reset  (reset),
    .load   (timer_load),
    .enable (state == RD_WAIT),
    .done   (lat_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr_out  <= '0;
      mem_wdata_out <= '0;
      mem_size_out  <= SIZE_BYTE;
      mem_re_out    <= 1'b0;
      mem_we_out    <= 1'b0;
      sel           <= SEL_IF;
      if_ready_out  <= 1'b0;
      dm_ready_out  <= 1'b0;
      if_data_out   <= '0;
      dm_rdata_out  <= '0;
    end else begin
      mem_re_out   <= issue_rd;
      mem_we_out   <= issue_wr;
      if_ready_out <= cap_if;
      dm_ready_out <= cap_dm || wr_ack;
      if (grant_if) begin
        mem_addr_out <= if_addr_in;
        mem_size_out <= SIZE_WORD;
        sel          <= SEL_IF;
      end else if (grant_dm) begin
        sel <= SEL_DM;
        if (!dm_misaligned) begin
          mem_addr_out  <= dm_addr_in;
          mem_size_out  <= dm_size_in;
          mem_wdata_out <= dm_wdata_in;
        end
      end
      if (cap_if) begin
        if_data_out <= mem_rdata_in;
      end
      if (cap_dm) begin
        dm_rdata_out <= mem_rdata_in;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_if) begin
      starve_cnt <= '0;
    end else if (grant_dm && if_req_in && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  assign stall_out = (if_req_in && !if_ready_out) || (dm_req_in && !dm_ready_out);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter; expected read data and grant
// order are queued when requests are driven and popped as the DUT responds.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

`ifdef MEM_ARB_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              if_req_in = 1'b0;
  logic [ADDR_W-1:0] if_addr_in = '0;
  logic              if_ready_out;
  logic [DATA_W-1:0] if_data_out;
  logic              dm_req_in = 1'b0;
  logic              dm_we_in = 1'b0;
  logic [1:0]        dm_size_in = SIZE_WORD;
  logic [ADDR_W-1:0] dm_addr_in = '0;
  logic [DATA_W-1:0] dm_wdata_in = '0;
  logic              dm_ready_out;
  logic [DATA_W-1:0] dm_rdata_out;
  logic              dm_err_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic [DATA_W-1:0] mem_wdata_out;
  logic              mem_re_out;
  logic              mem_we_out;
  logic [1:0]        mem_size_out;
  logic [DATA_W-1:0] mem_rdata_in = '0;
  logic              stall_out;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];
  bit grant_q[$];

  always #5 clock = ~clock;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clock(clock), .reset(reset),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in),
    .if_ready_out(if_ready_out), .if_data_out(if_data_out),
    .dm_req_in(dm_req_in), .dm_we_in(dm_we_in), .dm_size_in(dm_size_in),
    .dm_addr_in(dm_addr_in), .dm_wdata_in(dm_wdata_in),
    .dm_ready_out(dm_ready_out), .dm_rdata_out(dm_rdata_out), .dm_err_out(dm_err_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_re_out(mem_re_out), .mem_we_out(mem_we_out), .mem_size_out(mem_size_out),
    .mem_rdata_in(mem_rdata_in), .stall_out(stall_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_if_ready(output int n);
    n = 0;
    while (!if_ready_out && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_dm_ready(output int n);
    n = 0;
    while (!dm_ready_out && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({mem_re_out, mem_we_out, if_ready_out, dm_ready_out, dm_err_out, stall_out} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes got=%b exp=000000",
               {mem_re_out, mem_we_out, if_ready_out, dm_ready_out, dm_err_out, stall_out});
    end
    checks++;
    if ({mem_addr_out, mem_wdata_out, mem_size_out, if_data_out, dm_rdata_out} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data got addr=%h wdata=%h size=%b ifd=%h dmd=%h exp=all zero",
               mem_addr_out, mem_wdata_out, mem_size_out, if_data_out, dm_rdata_out);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_if_read();
    int n;
    logic [DATA_W-1:0] exp;
    if_addr_in   = 32'h0040_0000;
    mem_rdata_in = 32'h8C08_0004;
    if_req_in    = 1'b1;
    exp_q.push_back(32'h8C08_0004);
    tick();
    checks++;
    if ({mem_re_out, mem_we_out} !== 2'b10 || mem_addr_out !== 32'h0040_0000 || mem_size_out !== SIZE_WORD) begin
      failures++;
      $display("[TB] FAIL if_issue got re/we=%b addr=%h size=%b exp=10 00400000 11",
               {mem_re_out, mem_we_out}, mem_addr_out, mem_size_out);
    end
    checks++;
    if (stall_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL if_stall_busy got=%b exp=1", stall_out);
    end
    tick();
    checks++;
    if (mem_re_out !== 1'b0 || if_ready_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL if_strobe_width got re=%b rdy=%b exp=0 0", mem_re_out, if_ready_out);
    end
    wait_if_ready(n);
    checks++;
    if (n !== MEM_LAT - 1) begin
      failures++;
      $display("[TB] FAIL if_latency got=%0d exp=%0d", n, MEM_LAT - 1);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (if_data_out !== exp) begin
      failures++;
      $display("[TB] FAIL if_data got=%h exp=%h", if_data_out, exp);
    end
    checks++;
    if (stall_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL if_stall_ready got=%b exp=0", stall_out);
    end
    if_req_in = 1'b0;
    tick();
    checks++;
    if (if_ready_out !== 1'b0 || mem_re_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL if_ready_pulse got rdy=%b re=%b exp=0 0", if_ready_out, mem_re_out);
    end
  endtask

  task automatic test_dm_store();
    dm_addr_in  = 32'h1000_0010;
    dm_wdata_in = 32'hDEAD_BEEF;
    dm_size_in  = SIZE_WORD;
    dm_we_in    = 1'b1;
    dm_req_in   = 1'b1;
    tick();
    checks++;
    if ({mem_re_out, mem_we_out} !== 2'b01 || mem_addr_out !== 32'h1000_0010 ||
        mem_wdata_out !== 32'hDEAD_BEEF || mem_size_out !== SIZE_WORD) begin
      failures++;
      $display("[TB] FAIL st_issue got re/we=%b addr=%h wdata=%h size=%b exp=01 10000010 deadbeef 11",
               {mem_re_out, mem_we_out}, mem_addr_out, mem_wdata_out, mem_size_out);
    end
    tick();
    checks++;
    if ({dm_ready_out, mem_we_out, mem_re_out} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL st_done got rdy/we/re=%b exp=100", {dm_ready_out, mem_we_out, mem_re_out});
    end
    dm_req_in = 1'b0;
    dm_we_in  = 1'b0;
    tick();
    checks++;
    if (dm_ready_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL st_pulse got=%b exp=0", dm_ready_out);
    end
  endtask

  task automatic test_dm_load();
    int n;
    logic [DATA_W-1:0] exp;
    dm_addr_in   = 32'h1000_0040;
    dm_size_in   = SIZE_WORD;
    dm_we_in     = 1'b0;
    mem_rdata_in = 32'h1234_5678;
    dm_req_in    = 1'b1;
    exp_q.push_back(32'h1234_5678);
    tick();
    checks++;
    if (mem_re_out !== 1'b1 || mem_addr_out !== 32'h1000_0040) begin
      failures++;
      $display("[TB] FAIL ld_issue got re=%b addr=%h exp=1 10000040", mem_re_out, mem_addr_out);
    end
    wait_dm_ready(n);
    checks++;
    if (n !== MEM_LAT) begin
      failures++;
      $display("[TB] FAIL ld_latency got=%0d exp=%0d", n, MEM_LAT);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (dm_rdata_out !== exp || if_data_out !== 32'h8C08_0004) begin
      failures++;
      $display("[TB] FAIL ld_data got dm=%h if=%h exp=%h 8c080004", dm_rdata_out, if_data_out, exp);
    end
    dm_req_in = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    bit exp_dm;
    bit got_dm;
    int idx;
    dm_addr_in   = 32'h1000_0020;
    dm_size_in   = SIZE_WORD;
    dm_we_in     = 1'b0;
    if_addr_in   = 32'h0040_0100;
    mem_rdata_in = 32'h0;
    for (int i = 0; i < STARVE_MAX; i++) grant_q.push_back(1'b1);
    grant_q.push_back(1'b0);
    grant_q.push_back(1'b1);
    dm_req_in = 1'b1;
    if_req_in = 1'b1;
    idx = 0;
    for (int cyc = 0; cyc < 80 && grant_q.size() > 0; cyc++) begin
      tick();
      if (mem_re_out || mem_we_out) begin
        exp_dm = grant_q.pop_front();
        got_dm = (mem_addr_out == 32'h1000_0020);
        checks++;
        if (got_dm !== exp_dm) begin
          failures++;
          $display("[TB] FAIL starve_grant%0d got dm=%b exp dm=%b", idx, got_dm, exp_dm);
        end
        idx++;
      end
    end
    checks++;
    if (grant_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL starve_timeout got remaining=%0d exp=0", grant_q.size());
      grant_q.delete();
    end
    dm_req_in = 1'b0;
    if_req_in = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int n;
    int bad;
    logic [DATA_W-1:0] exp;
    if_addr_in   = 32'h0040_0200;
    mem_rdata_in = 32'hCAFE_F00D;
    if_req_in    = 1'b1;
    tick();
    checks++;
    if (mem_re_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rst_mid_issue got re=%b exp=1", mem_re_out);
    end
    #2;
    reset     = 1'b1;
    if_req_in = 1'b0;
    #1;
    checks++;
    if ({mem_re_out, mem_we_out, if_ready_out, dm_ready_out, dm_err_out, stall_out} !== 6'b0 ||
        mem_addr_out !== '0 || if_data_out !== '0 || dm_rdata_out !== '0) begin
      failures++;
      $display("[TB] FAIL rst_mid_clear got flags=%b addr=%h ifd=%h dmd=%h exp=all zero",
               {mem_re_out, mem_we_out, if_ready_out, dm_ready_out, dm_err_out, stall_out},
               mem_addr_out, if_data_out, dm_rdata_out);
    end
    #2;
    reset = 1'b0;
    bad = 0;
    repeat (4) begin
      tick();
      if (if_ready_out !== 1'b0 || mem_re_out !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("[TB] FAIL rst_mid_no_ready got=%0d exp=0", bad);
    end
    exp_q.push_back(32'hCAFE_F00D);
    if_req_in = 1'b1;
    tick();
    wait_if_ready(n);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (n !== MEM_LAT || if_data_out !== exp) begin
      failures++;
      $display("[TB] FAIL rst_mid_reissue got lat=%0d data=%h exp=%0d %h", n, if_data_out, MEM_LAT, exp);
    end
    if_req_in = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int issue_t[$];
    int t;
    int readies;
    int gap1;
    int gap2;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] exp;
    if_addr_in = 32'h0040_0300;
    word       = 32'hA000_0000;
    t          = 0;
    readies    = 0;
    if_req_in  = 1'b1;
    for (int cyc = 0; cyc < 40 && readies < 3; cyc++) begin
      tick();
      t++;
      if (if_ready_out) begin
        readies++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (if_data_out !== exp) begin
          failures++;
          $display("[TB] FAIL b2b_data%0d got=%h exp=%h", readies, if_data_out, exp);
        end
        if (readies == 3) if_req_in = 1'b0;
      end
      if (mem_re_out) begin
        issue_t.push_back(t);
        word         = word + 32'h1;
        mem_rdata_in = word;
        exp_q.push_back(word);
      end
    end
    repeat (3) begin
      tick();
      t++;
      if (mem_re_out) issue_t.push_back(t);
    end
    checks++;
    if (issue_t.size() !== 3) begin
      failures++;
      $display("[TB] FAIL b2b_issue_count got=%0d exp=3", issue_t.size());
    end
    gap1 = (issue_t.size() > 1) ? issue_t[1] - issue_t[0] : -1;
    gap2 = (issue_t.size() > 2) ? issue_t[2] - issue_t[1] : -1;
    checks++;
    if (gap1 !== MEM_LAT + 1 || gap2 !== MEM_LAT + 1) begin
      failures++;
      $display("[TB] FAIL b2b_spacing got=%0d,%0d exp=%0d", gap1, gap2, MEM_LAT + 1);
    end
    exp_q.delete();
  endtask

  task automatic test_alignment();
    bit saw_re;
    bit err_at_ready;
    int ready_t;
    bit exp_re;
    bit exp_err;
    int exp_t;
    exp_re  = !ALIGN_EN;
    exp_err = ALIGN_EN;
    exp_t   = ALIGN_EN ? 2 : MEM_LAT + 1;
    dm_addr_in   = 32'h1000_0002;
    dm_size_in   = SIZE_WORD;
    dm_we_in     = 1'b0;
    mem_rdata_in = 32'h55AA_55AA;
    dm_req_in    = 1'b1;
    saw_re       = 1'b0;
    err_at_ready = 1'b0;
    ready_t      = -1;
    for (int t = 1; t <= 6 && ready_t < 0; t++) begin
      tick();
      if (mem_re_out) saw_re = 1'b1;
      if (dm_ready_out) begin
        ready_t      = t;
        err_at_ready = dm_err_out;
        dm_req_in    = 1'b0;
      end
    end
    checks++;
    if (saw_re !== exp_re || err_at_ready !== exp_err || ready_t !== exp_t) begin
      failures++;
      $display("[TB] FAIL align_word got re=%b err=%b rdy_t=%0d exp=%b %b %0d",
               saw_re, err_at_ready, ready_t, exp_re, exp_err, exp_t);
    end
    dm_req_in = 1'b0;
    tick();
    checks++;
    if (dm_err_out !== 1'b0 || dm_ready_out !== 1'b0) begin
      failures++;
      $display("[TB] FAIL align_pulse got err=%b rdy=%b exp=0 0", dm_err_out, dm_ready_out);
    end
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_dm_store();
    test_dm_load();
    test_starvation();
    test_reset_mid();
    test_back_to_back();
    test_alignment();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single data_memory port between two requesters: instruction fetch (IF) and the pipeline's load/store stage (DM).
- Issues one access at a time, waits the fixed memory read latency, returns data with a one-cycle ready pulse, and raises a pipeline stall while any request is outstanding.
- Sits between the PC/fetch logic, the load/store stage and data_memory. Serial IO stays wired straight to data_memory.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LAT, 2, edges from the issue edge to the edge that captures mem_rdata_in. Must be >= 1.
- STARVE_MAX, 4, consecutive DM grants allowed while an IF request is pending.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high.
- if_req_in  in  1  fetch request; level, held until if_ready_out.
- if_addr_in  in  ADDR_W  fetch address.
- if_ready_out  out  1  one-cycle pulse; if_data_out valid.
- if_data_out  out  DATA_W  fetched word, registered.
- dm_req_in  in  1  load/store request; level.
- dm_we_in  in  1  1 = store, 0 = load.
- dm_size_in  in  2  access size.
- dm_addr_in  in  ADDR_W  access address.
- dm_wdata_in  in  DATA_W  store data.
- dm_ready_out  out  1  one-cycle completion pulse.
- dm_rdata_out  out  DATA_W  load data, registered.
- dm_err_out  out  1  misalignment flag (see Optional Feature).
- mem_addr_out  out  ADDR_W  to data_memory addr_in.
- mem_wdata_out  out  DATA_W  to data_memory writedata_in.
- mem_re_out  out  1  to re_in.
- mem_we_out  out  1  to we_in.
- mem_size_out  out  2  to size_in.
- mem_rdata_in  in  DATA_W  from readdata_out.
- stall_out  out  1  high while any request is pending or in flight.

Behaviour:
- Reset (async, immediate):
  - FSM to IDLE; lat_cnt = 0, starve_cnt = 0.
  - All mem_* outputs, ready pulses, data outputs and dm_err_out go to 0.
  - Any in-flight access is abandoned and no ready pulse is ever issued for it.
- FSM states: IDLE, RD_WAIT, WR_DONE.
- Arbitration, at an edge in IDLE:
  - Only dm_req_in: grant DM.
  - Only if_req_in: grant IF.
  - Both: grant DM, unless starve_cnt == STARVE_MAX, in which case grant IF.
- starve_cnt:
  - Increments on a DM grant while if_req_in is high.
  - Clears on any IF grant.
  - Saturates at STARVE_MAX.
- Issue edge E:
  - mem_addr/wdata/size outputs register the granted request.
  - mem_re_out or mem_we_out is high for exactly the one cycle after E.
  - IF always issues a read with size = WORD.
- Loads and fetches:
  - Go to RD_WAIT; lat_cnt loads MEM_LAT-1.
  - At edge E+MEM_LAT, mem_rdata_in is captured into the requester's data output and that requester's ready is high for one cycle.
  - The FSM returns to IDLE at that same edge.
- Stores:
  - Go to WR_DONE; dm_ready_out pulses after edge E+1, then IDLE.
- Ready-cycle rule: a req still high during the requester's ready cycle counts as a new request. Throughput is one read per MEM_LAT+1 cycles.
- Data outputs hold their last value until the next capture.
- Address, size and wdata must stay stable while req is high. Changes after issue are ignored.
- stall_out = (if_req_in & ~if_ready_out) | (dm_req_in & ~dm_ready_out). It is combinational.

Optional Feature:
- Macro: MEM_ARB_ALIGN_CHECK_EN.
- When defined, a DM request is misaligned if size == HALF with addr[0] = 1, or size == WORD with addr[1:0] != 0.
  - The misaligned access gets no memory strobe.
  - dm_ready_out and dm_err_out pulse together one edge after the grant.
  - starve_cnt is still updated.
- When not defined, dm_err_out is tied to 0 and every access is issued unchanged.

Decomposition:
- Package mem_arb_pkg:
  - State enum {IDLE, RD_WAIT, WR_DONE}.
  - Size constants: SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b11.
  - Requester-select encoding.
- One sub-module, mem_arb_lat_timer: a loadable down-counter with a done pulse, parameterised by MEM_LAT.

Test Plan:
- IF-only read (MEM_LAT = 2): if_req = 1, addr 0x00400000, mem returns 0x8C080004.
  - mem_re high one cycle after the issue edge; if_ready pulses two edges after issue with if_data = 0x8C080004.
  - stall_out drops in the ready cycle.
- DM store: dm_req = 1, we = 1, addr 0x10000010, wdata 0xDEADBEEF, size WORD.
  - mem_we one cycle with exact addr/data; dm_ready pulses after edge E+1; mem_re stays 0.
- Starvation guard: dm_req and if_req held continuously.
  - DM wins 4 consecutive grants, the 5th grant goes to IF, then starve_cnt = 0.
- Reset during RD_WAIT (async, mid-cycle).
  - All outputs go to 0 immediately; no if_ready pulse afterwards; the next request issues normally.
- Back-to-back fetches: if_req held high across the ready cycle.
  - Reissue occurs the edge after ready; issue edges are spaced 3 cycles apart.
- Alignment (with MEM_ARB_ALIGN_CHECK_EN): load WORD at 0x10000002.
  - dm_err and dm_ready pulse together; no mem_re.
  - Without the macro, mem_re is issued and dm_err stays 0.
